prach_cplane_dispatch: RTL and testbench

- Sits in the eth/xran clock domain, upstream of the PRACH buffer's C-plane inputs.
- Accepts parsed PRACH C-plane section descriptors from the xran parser over a valid/ready stream.
- Decodes the eAxC id to a (cc, ant) channel, validates the section, and issues a single-cycle c_valid strobe to exactly one channel.
- Holds the shared c_header/c_time_offset/c_num_symbol bus stable long enough for the per-channel buffers to capture it across their clock crossing.

---
 rtl/prach_cplane_dispatch.sv | 191 +++++++++++++++++++
 tb/tb_prach_cplane_dispatch.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_cplane_dispatch.sv
`timescale 1ns/1ps
// prach_cplane_dispatch
// Queues parsed PRACH C-plane section descriptors, validates each one and
// fires a single-cycle strobe to the (cc, ant) channel it addresses. The shared
// header/time-offset/symbol bus is frozen for at least HOLD_CYCLES cycles after
// each strobe so the per-channel buffers can capture it across their crossing.
// Optional: define PRACH_CPLANE_STATS_EN to add issued/dropped counters.
module prach_cplane_dispatch #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          HOLD_CYCLES     = 8,
    parameter logic [19:0] MAX_TIME_OFFSET = 20'd30720
) (
    input  logic            clk_eth_xran,
    input  logic            rst_eth_xran_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [7:0]      s_eaxc_id,
    input  logic [119:0]    s_header,
    input  logic [19:0]     s_time_offset,
    input  logic [3:0]      s_num_symbol,
    output logic [2:0][7:0] c_valid,
    output logic [119:0]    c_header,
    output logic [19:0]     c_time_offset,
    output logic [3:0]      c_num_symbol,
    output logic            drop_pulse,
    output logic            busy
`ifdef PRACH_CPLANE_STATS_EN
    ,
    input  logic            stat_clear,
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_dropped
`endif
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int HW  = $clog2(HOLD_CYCLES);
    localparam int DW  = 8 + 120 + 20 + 4;

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_ISSUE, ST_HOLD} state_t;

    state_t          state_reg;
    logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            s_ready_reg;
    logic [DW-1:0]   w_desc_reg;
    logic [HW-1:0]   hold_cnt_reg;

    logic            push;
    logic            pop;
    logic [DW-1:0]   s_desc;
    logic [7:0]      w_eaxc;
    logic [119:0]    w_header;
    logic [19:0]     w_time_offset;
    logic [3:0]      w_num_symbol;
    logic            desc_ok;
    logic [2:0][7:0] strobe_sel;

    assign s_desc        = {s_eaxc_id, s_header, s_time_offset, s_num_symbol};
    assign push          = s_valid && s_ready_reg;
    assign pop           = (state_reg == ST_IDLE) && (count_reg != '0);
    assign s_ready       = s_ready_reg;
    assign busy          = (state_reg != ST_IDLE) || (count_reg != '0);

    assign w_eaxc        = w_desc_reg[151:144];
    assign w_header      = w_desc_reg[143:24];
    assign w_time_offset = w_desc_reg[23:4];
    assign w_num_symbol  = w_desc_reg[3:0];

    // Only 3 component carriers x 8 antennas exist downstream.
    assign desc_ok = (w_eaxc[7:4] <= 4'd2) && (w_eaxc[3:0] <= 4'd7) &&
                     (w_num_symbol != 4'd0) && (w_time_offset < MAX_TIME_OFFSET);

    // One-hot channel select decoded from the working descriptor's eAxC id.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cc
            for (gj = 0; gj < 8; gj++) begin : g_ant
                assign strobe_sel[gi][gj] = (w_eaxc[7:4] == 4'(gi)) && (w_eaxc[3:0] == 4'(gj));
            end
        end
    endgenerate

    // Descriptor storage; contents need no reset since the count guards reads.
    always_ff @(posedge clk_eth_xran) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= s_desc;
        end
    end

    // FIFO pointers and occupancy. s_ready is computed from the count before
    // any same-cycle pop, so a full FIFO stays stalled for one extra cycle.
    always_ff @(posedge clk_eth_xran or negedge rst_eth_xran_n) begin
        if (!rst_eth_xran_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            s_ready_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg   <= count_reg + CW'(push) - CW'(pop);
            s_ready_reg <= (CW1'(count_reg) + CW1'(push)) < CW1'(FIFO_DEPTH);
        end
    end

    // Dispatch FSM with registered strobe, drop pulse and shared bus.
    // HOLD lasts HOLD_CYCLES-1 cycles; together with the strobe cycle the bus
    // is frozen HOLD_CYCLES cycles, and it only changes again at the next ISSUE.
    always_ff @(posedge clk_eth_xran or negedge rst_eth_xran_n) begin
        if (!rst_eth_xran_n) begin
            state_reg     <= ST_IDLE;
            w_desc_reg    <= '0;
            hold_cnt_reg  <= '0;
            c_valid       <= '0;
            c_header      <= '0;
            c_time_offset <= '0;
            c_num_symbol  <= '0;
            drop_pulse    <= 1'b0;
        end else begin
            c_valid    <= '0;
            drop_pulse <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        w_desc_reg <= fifo_mem[rd_ptr_reg];
                        state_reg  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (desc_ok) begin
                        state_reg <= ST_ISSUE;
                    end else begin
                        drop_pulse <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    c_valid       <= strobe_sel;
                    c_header      <= w_header;
                    c_time_offset <= w_time_offset;
                    c_num_symbol  <= w_num_symbol;
                    hold_cnt_reg  <= HW'(HOLD_CYCLES - 1);
                    state_reg     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_reg <= HW'(1)) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef PRACH_CPLANE_STATS_EN
    logic issue_evt;
    logic drop_evt;
    assign issue_evt = (state_reg == ST_ISSUE);
    assign drop_evt  = (state_reg == ST_CHECK) && !desc_ok;

    // Saturating issue/drop counters; a clear wins over a same-cycle event.
    always_ff @(posedge clk_eth_xran or negedge rst_eth_xran_n) begin
        if (!rst_eth_xran_n) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
        end else if (stat_clear) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
        end else begin
            if (issue_evt && (stat_issued != 32'hFFFF_FFFF)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (drop_evt && (stat_dropped != 32'hFFFF_FFFF)) begin
                stat_dropped <= stat_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prach_cplane_dispatch.sv
`timescale 1ns/1ps
// Testbench for prach_cplane_dispatch: timeline reference model (queue plus
// "engine free at edge N" bookkeeping) checked every cycle, plus directed
// literal checks for latency, spacing, drops, channel coverage and reset.
module tb_prach_cplane_dispatch;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int MAXTO = 30720;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [7:0]      s_eaxc_id = '0;
    logic [119:0]    s_header = '0;
    logic [19:0]     s_time_offset = '0;
    logic [3:0]      s_num_symbol = '0;
    logic [2:0][7:0] c_valid;
    logic [119:0]    c_header;
    logic [19:0]     c_time_offset;
    logic [3:0]      c_num_symbol;
    logic            drop_pulse;
    logic            busy;
`ifdef PRACH_CPLANE_STATS_EN
    logic            stat_clear = 1'b0;
    logic [31:0]     stat_issued;
    logic [31:0]     stat_dropped;
`endif

    always #5 clk = ~clk;

    prach_cplane_dispatch #(
        .FIFO_DEPTH     (DEPTH),
        .HOLD_CYCLES    (HOLD),
        .MAX_TIME_OFFSET(20'd30720)
    ) dut (
        .clk_eth_xran  (clk),
        .rst_eth_xran_n(rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_eaxc_id     (s_eaxc_id),
        .s_header      (s_header),
        .s_time_offset (s_time_offset),
        .s_num_symbol  (s_num_symbol),
        .c_valid       (c_valid),
        .c_header      (c_header),
        .c_time_offset (c_time_offset),
        .c_num_symbol  (c_num_symbol),
        .drop_pulse    (drop_pulse),
        .busy          (busy)
`ifdef PRACH_CPLANE_STATS_EN
        ,
        .stat_clear    (stat_clear),
        .stat_issued   (stat_issued),
        .stat_dropped  (stat_dropped)
`endif
    );

    typedef struct packed {
        logic [7:0]   eaxc;
        logic [119:0] hdr;
        logic [19:0]  to;
        logic [3:0]   ns;
    } desc_t;

    // Reference model state
    desc_t        q[$];
    int           edge_n;
    int           engine_free;
    bit           pend_on;
    bit           pend_is_strobe;
    int           pend_edge;
    desc_t        pend_d;
    logic [23:0]  exp_cv;
    logic [119:0] exp_hdr;
    logic [19:0]  exp_to;
    logic [3:0]   exp_ns;
    logic         exp_drop, exp_ready, exp_busy;
    logic [31:0]  exp_issued, exp_dropped;

    // Observations of the DUT for literal checks
    int strobe_edges[$];
    int drop_total;
    int hits[24];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit desc_ok(input desc_t d);
        return (d.eaxc[7:4] <= 4'd2) && (d.eaxc[3:0] <= 4'd7) && (d.ns != 4'd0) && (int'(d.to) < MAXTO);
    endfunction

    task automatic model_reset();
        q.delete();
        pend_on     = 1'b0;
        engine_free = 0;
        exp_cv      = '0;
        exp_hdr     = '0;
        exp_to      = '0;
        exp_ns      = '0;
        exp_drop    = 1'b0;
        exp_ready   = 1'b0;
        exp_busy    = 1'b0;
        exp_issued  = '0;
        exp_dropped = '0;
    endtask

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_edge();
        bit    push;
        int    size_pre;
        desc_t d;
`ifdef PRACH_CPLANE_STATS_EN
        bit    iss;
        bit    drp;
        iss = 1'b0;
        drp = 1'b0;
`endif
        push     = s_valid && exp_ready;
        size_pre = q.size();
        exp_cv   = '0;
        exp_drop = 1'b0;
        if (pend_on && pend_edge == edge_n) begin
            if (pend_is_strobe) begin
                exp_cv[int'(pend_d.eaxc[7:4]) * 8 + int'(pend_d.eaxc[3:0])] = 1'b1;
                exp_hdr = pend_d.hdr;
                exp_to  = pend_d.to;
                exp_ns  = pend_d.ns;
`ifdef PRACH_CPLANE_STATS_EN
                iss = 1'b1;
`endif
            end else begin
                exp_drop = 1'b1;
`ifdef PRACH_CPLANE_STATS_EN
                drp = 1'b1;
`endif
            end
            pend_on = 1'b0;
        end
        if (size_pre > 0 && edge_n >= engine_free) begin
            d         = q.pop_front();
            pend_on   = 1'b1;
            pend_d    = d;
            if (desc_ok(d)) begin
                pend_is_strobe = 1'b1;
                pend_edge      = edge_n + 2;
                engine_free    = edge_n + HOLD + 2;
            end else begin
                pend_is_strobe = 1'b0;
                pend_edge      = edge_n + 1;
                engine_free    = edge_n + 2;
            end
        end
        if (push) begin
            d = '{eaxc: s_eaxc_id, hdr: s_header, to: s_time_offset, ns: s_num_symbol};
            q.push_back(d);
            $display("accept edge=%0d eaxc=%02h to=%0d ns=%0d", edge_n, d.eaxc, d.to, d.ns);
        end
        exp_ready = (size_pre + int'(push)) < DEPTH;
        exp_busy  = (q.size() > 0) || (edge_n + 1 < engine_free);
`ifdef PRACH_CPLANE_STATS_EN
        if (stat_clear) begin
            exp_issued  = '0;
            exp_dropped = '0;
        end else begin
            if (iss && exp_issued != 32'hFFFF_FFFF) exp_issued = exp_issued + 32'd1;
            if (drp && exp_dropped != 32'hFFFF_FFFF) exp_dropped = exp_dropped + 32'd1;
        end
`endif
        edge_n++;
    endtask

    task automatic compare_all();
        chk("c_valid", c_valid, exp_cv);
        chk("c_header", c_header, exp_hdr);
        chk("c_time_offset", c_time_offset, exp_to);
        chk("c_num_symbol", c_num_symbol, exp_ns);
        chk("drop_pulse", drop_pulse, exp_drop);
        chk("s_ready", s_ready, exp_ready);
        chk("busy", busy, exp_busy);
`ifdef PRACH_CPLANE_STATS_EN
        chk("stat_issued", stat_issued, exp_issued);
        chk("stat_dropped", stat_dropped, exp_dropped);
`endif
        if (c_valid != '0) begin
            chk("c_valid_onehot", 128'($countones(c_valid)), 128'd1);
            strobe_edges.push_back(edge_n - 1);
            for (int i = 0; i < 24; i++) begin
                if (c_valid[i / 8][i % 8]) hits[i]++;
            end
        end
        if (drop_pulse) drop_total++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_quiet();
        int guard;
        guard = 0;
        while ((exp_busy || pend_on || q.size() > 0) && guard < 500) begin
            tick();
            guard++;
        end
        chk("quiet_timeout", 128'(guard < 500), 128'd1);
        idle(2);
    endtask

    // Called at a falling edge; reset is asynchronous so outputs clear at once.
    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] eaxc, input logic [19:0] to,
                        input logic [3:0] ns, output int acc_edge);
        logic [127:0] r;
        bit acc;
        int guard;
        r             = {$urandom, $urandom, $urandom, $urandom};
        s_valid       = 1'b1;
        s_eaxc_id     = eaxc;
        s_header      = r[119:0];
        s_time_offset = to;
        s_num_symbol  = ns;
        acc           = 1'b0;
        guard         = 0;
        acc_edge      = -1;
        while (!acc && guard < 100) begin
            acc = exp_ready;
            if (acc) acc_edge = edge_n;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        chk("accept_timeout", 128'(acc), 128'd1);
    endtask

    task automatic rand_desc();
        logic [127:0] r;
        int sel;
        r        = {$urandom, $urandom, $urandom, $urandom};
        s_header = r[119:0];
        if ($urandom_range(0, 3) != 0) begin
            s_eaxc_id = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 7))};
        end else begin
            s_eaxc_id = 8'($urandom);
        end
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      s_time_offset = 20'd30719;
        else if (sel == 1) s_time_offset = 20'd30720;
        else if (sel == 2) s_time_offset = 20'($urandom);
        else               s_time_offset = 20'($urandom_range(0, 30719));
        s_num_symbol = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int s0;
        int d0;
        edge_n     = 0;
        drop_total = 0;
        for (int i = 0; i < 24; i++) hits[i] = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        tick();

        // Single valid section: strobe on [1][3] three edges after acceptance.
        s0 = strobe_edges.size();
        d0 = drop_total;
        send(8'h13, 20'd100, 4'd12, a);
        idle(14);
        chk("single_strobe_count", 128'(strobe_edges.size() - s0), 128'd1);
        if (strobe_edges.size() > s0) chk("single_latency", 128'(strobe_edges[s0] - a), 128'd3);
        chk("single_hit_1_3", 128'(hits[11]), 128'd1);
        chk("single_time_offset", c_time_offset, 128'd100);
        chk("single_num_symbol", c_num_symbol, 128'd12);
        chk("single_no_drop", 128'(drop_total - d0), 128'd0);

        // Four invalid sections: bad cc, bad ant, zero symbols, offset at limit.
        s0 = strobe_edges.size();
        d0 = drop_total;
        send(8'h30, 20'd100, 4'd12, a);
        send(8'h08, 20'd100, 4'd12, a);
        send(8'h13, 20'd100, 4'd0, a);
        send(8'h13, 20'd30720, 4'd12, a);
        wait_quiet();
        chk("invalid_drops", 128'(drop_total - d0), 128'd4);
        chk("invalid_no_strobe", 128'(strobe_edges.size() - s0), 128'd0);
        chk("invalid_bus_kept", c_time_offset, 128'd100);

        // Back-to-back burst of six: strobes exactly HOLD+2 edges apart.
        s0 = strobe_edges.size();
        for (int k = 0; k < 6; k++) send(8'(k), 20'(1000 + k), 4'd4, a);
        wait_quiet();
        chk("burst_count", 128'(strobe_edges.size() - s0), 128'd6);
        for (int k = 1; k < 6; k++) begin
            if (strobe_edges.size() > s0 + k)
                chk("burst_spacing", 128'(strobe_edges[s0 + k] - strobe_edges[s0 + k - 1]), 128'd10);
        end

        // Every valid channel once.
        for (int i = 0; i < 24; i++) hits[i] = 0;
        for (int cc = 0; cc < 3; cc++)
            for (int ant = 0; ant < 8; ant++)
                send({4'(cc), 4'(ant)}, 20'(cc * 100 + ant), 4'd2, a);
        wait_quiet();
        for (int i = 0; i < 24; i++) chk("channel_once", 128'(hits[i]), 128'd1);

        // Reset three cycles into HOLD with two descriptors still queued.
        s0 = strobe_edges.size();
        send(8'h21, 20'd7, 4'd1, a);
        send(8'h22, 20'd8, 4'd1, a);
        send(8'h23, 20'd9, 4'd1, a);
        for (int g = 0; g < 20 && strobe_edges.size() == s0; g++) tick();
        idle(3);
        do_reset();
        s0 = strobe_edges.size();
        idle(20);
        chk("post_reset_no_strobe", 128'(strobe_edges.size() - s0), 128'd0);
        chk("post_reset_ready", s_ready, 128'd1);

`ifdef PRACH_CPLANE_STATS_EN
        for (int k = 0; k < 5; k++) send(8'h10, 20'(k), 4'd3, a);
        for (int k = 0; k < 3; k++) send(8'hF0, 20'(k), 4'd3, a);
        wait_quiet();
        chk("stat_issued_5", stat_issued, 128'd5);
        chk("stat_dropped_3", stat_dropped, 128'd3);
        send(8'h02, 20'd5, 4'd3, a);
        for (int g = 0; g < 20 && !(pend_on && pend_is_strobe && pend_edge == edge_n); g++) tick();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        chk("stat_clear_priority", stat_issued, 128'd0);
        wait_quiet();
`endif

        // Randomised traffic with stable data while stalled.
        for (int i = 0; i < 400; i++) begin
            if (!(s_valid && !exp_ready)) begin
                s_valid = 1'($urandom_range(0, 1));
                rand_desc();
            end
`ifdef PRACH_CPLANE_STATS_EN
            stat_clear = ($urandom_range(0, 31) == 0);
`endif
            tick();
        end
        s_valid = 1'b0;
`ifdef PRACH_CPLANE_STATS_EN
        stat_clear = 1'b0;
`endif
        wait_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
